// File: rtl/encoder_pkg.sv
// Shared constants and width helper for the request-to-index encoder.
package encoder_pkg;

  localparam int ENC_N_DEFAULT = 8;

  // Index width for an n-entry vector; never below one bit so y always exists.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/encoder_prio_core.sv
// Combinational MSB-priority encoder: index of highest set bit, any and multi-hot flags.
module encoder_prio_core
  import encoder_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] a,
  input  logic         en,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  // Walk LSB to MSB so the last set bit seen (the highest) wins.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    multi = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (a[i]) begin
          multi = any;
          idx   = W'(i);
          any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/encoder.sv
// Registered priority encoder: one-cycle latency, outputs cleared asynchronously on reset.
module encoder
  import encoder_pkg::*;
#(
  parameter int N = ENC_N_DEFAULT,
  parameter int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic         en,
  output logic [W-1:0] y,
  output logic         valid,
  output logic         multi
);

  logic [W-1:0] idx_c;
  logic         any_c;
  logic         multi_c;

  encoder_prio_core #(.N(N), .W(W)) u_core (
    .a     (a),
    .en    (en),
    .idx   (idx_c),
    .any   (any_c),
    .multi (multi_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y     <= '0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      y     <= idx_c;
      valid <= any_c;
      multi <= multi_c;
    end
  end

endmodule

// File: tb/tb_encoder.sv
// Directed and random checks of the registered 8-to-3 priority encoder.
module tb_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic       en = 1'b0;
  logic [2:0] y;
  logic       valid;
  logic       multi;

  int n_checks = 0;
  int n_fail   = 0;

  encoder #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .en    (en),
    .y     (y),
    .valid (valid),
    .multi (multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] ey, input logic ev, input logic em);
    n_checks += 3;
    assert (y === ey) else begin
      n_fail++;
      $error("FAIL %s y=%0d expected %0d", tag, y, ey);
    end
    assert (valid === ev) else begin
      n_fail++;
      $error("FAIL %s valid=%0b expected %0b", tag, valid, ev);
    end
    assert (multi === em) else begin
      n_fail++;
      $error("FAIL %s multi=%0b expected %0b", tag, multi, em);
    end
  endtask

  // Apply inputs, let one rising edge sample them, then settle 1 time unit.
  task automatic step(input logic [7:0] av, input logic ev);
    a  = av;
    en = ev;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ra;
    logic       ren;
    logic [2:0] ey;
    logic       evl;
    logic       em;
    logic       found;

    // Reset held with a busy input
    rst_n = 1'b0;
    en    = 1'b1;
    a     = 8'hFF;
    #2;
    chk("reset_t0", 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("reset_held1", 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("reset_held2", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("reset_released_no_edge", 3'd0, 1'b0, 1'b0);
    step(8'hFF, 1'b1);
    chk("after_reset_ff", 3'd7, 1'b1, 1'b1);

    // One-hot sweep
    for (int i = 0; i < 8; i++) begin
      step(8'h01 << i, 1'b1);
      chk($sformatf("onehot_%0d", i), 3'(i), 1'b1, 1'b0);
    end

    // Disable with X on a, then plain disable and re-enable
    step(8'hxx, 1'b0);
    chk("disable_x", 3'd0, 1'b0, 1'b0);
    step(8'h20, 1'b0);
    chk("disable_20", 3'd0, 1'b0, 1'b0);
    step(8'h20, 1'b1);
    chk("enable_20", 3'd5, 1'b1, 1'b0);

    // Zero vs request 0
    step(8'h00, 1'b1);
    chk("zero", 3'd0, 1'b0, 1'b0);
    step(8'h01, 1'b1);
    chk("req0", 3'd0, 1'b1, 1'b0);

    // Priority
    step(8'b0101_0010, 1'b1);
    chk("prio_52", 3'd6, 1'b1, 1'b1);
    step(8'h03, 1'b1);
    chk("prio_03", 3'd1, 1'b1, 1'b1);
    step(8'h80, 1'b1);
    chk("prio_80", 3'd7, 1'b1, 1'b0);

    // Asynchronous reset between edges while valid = 1
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mid", 3'd0, 1'b0, 1'b0);
    a  = 8'h90;
    en = 1'b1;
    @(posedge clk); #1;
    chk("async_held", 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(8'h0C, 1'b1);
    chk("async_release", 3'd3, 1'b1, 1'b1);

    // Random stimulus against a top-down reference scan
    for (int n = 0; n < 1000; n++) begin
      ra  = 8'($urandom);
      ren = ($urandom_range(0, 3) != 0);
      ey  = 3'd0;
      evl = 1'b0;
      em  = 1'b0;
      found = 1'b0;
      if (ren) begin
        for (int b = 7; b >= 0; b--) begin
          if (ra[b] && !found) begin
            ey    = 3'(b);
            found = 1'b1;
          end
        end
        evl = (ra != 8'h00);
        em  = ($countones(ra) > 1);
      end
      step(ra, ren);
      chk("random", ey, evl, em);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
